sort_ctrl_mb: RTL and testbench



---
 rtl/sort_ctrl_pkg.sv | 30 +++
 rtl/sort_ctrl_bank_fsm.sv | 59 +++++
 rtl/sort_ctrl_mb.sv | 172 +++++++++++++++++
 tb/tb_sort_ctrl_mb.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sort_ctrl_pkg
// Purpose  : Shared definitions for the multi-bank sort controller:
//            per-bank state encoding and the wrapping pointer increment.
// Revision : 1.0 - initial multi-bank release
// ============================================================================
package sort_ctrl_pkg;

    localparam int c_state_w = 3;

    localparam logic [c_state_w-1:0] c_st_idle    = 3'd0;
    localparam logic [c_state_w-1:0] c_st_wr_data = 3'd1;
    localparam logic [c_state_w-1:0] c_st_wr_wait = 3'd2;
    localparam logic [c_state_w-1:0] c_st_rd_pend = 3'd3;
    localparam logic [c_state_w-1:0] c_st_rd_data = 3'd4;

    // Bank pointers count 0..num_bank-1 and wrap explicitly, so a
    // non-power-of-two bank count never visits an unused id.
    function automatic logic [3:0] ptr_inc(input logic [3:0] ptr,
                                           input logic [4:0] num_bank);
        if ({1'b0, ptr} == (num_bank - 5'd1)) begin
            ptr_inc = 4'd0;
        end else begin
            ptr_inc = ptr + 4'd1;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/sort_ctrl_bank_fsm.sv
`default_nettype none
// ============================================================================
// Module   : sort_ctrl_bank_fsm
// Purpose  : Lifecycle FSM of one sort bank:
//            IDLE -> WR_DATA -> WR_WAIT -> RD_PEND -> RD_DATA -> IDLE.
//            All strobes arrive already qualified for this bank by the top.
// Ports    : clk, rst          clock, synchronous active-high reset
//            i_accept          job accepted into this bank
//            i_input_done      last input of this bank has been sent
//            i_wr_done         count unit finished writing this bank
//            i_rd_grant        read start issued for this bank
//            i_rd_done         read unit finished this bank
//            i_timeout         read watchdog expired on this bank
//            o_state           current state
// Revision : 1.0 - initial multi-bank release
// ============================================================================
module sort_ctrl_bank_fsm
    import sort_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_accept,
    input  logic                 i_input_done,
    input  logic                 i_wr_done,
    input  logic                 i_rd_grant,
    input  logic                 i_rd_done,
    input  logic                 i_timeout,
    output logic [c_state_w-1:0] o_state
);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Each strobe only acts in its own state; wr_done seen in WR_DATA is
    // dropped, which forces input_done to be registered first.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:    if (i_accept)              w_state_nxt = c_st_wr_data;
            c_st_wr_data: if (i_input_done)          w_state_nxt = c_st_wr_wait;
            c_st_wr_wait: if (i_wr_done)             w_state_nxt = c_st_rd_pend;
            c_st_rd_pend: if (i_rd_grant)            w_state_nxt = c_st_rd_data;
            c_st_rd_data: if (i_rd_done | i_timeout) w_state_nxt = c_st_idle;
            default:                                 w_state_nxt = c_st_idle;
        endcase
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/sort_ctrl_mb.sv
`default_nettype none
// ============================================================================
// Module   : sort_ctrl_mb
// Purpose  : Multi-bank sort controller. Allocates NUM_BANK sort buffers
//            round-robin, gates count-unit write completion against the
//            input-done flag and issues read starts to the priority read
//            unit strictly in allocation order.
// Options  : SORT_CTRL_RD_TIMEOUT_EN - enables the read watchdog
//            (TIMEOUT_CYC cycles); otherwise ctrl_timeout_o is tied 0.
// Ports    : clk, rst                  clock, synchronous active-high reset
//            ctrl_vld_i / ctrl_rdy_o   new-job handshake
//            ctrl_bank_o               bank given to a job accepted now
//            ctrl_input_done_vld_i     last input of the writing bank sent
//            cntu2ctrl_wr_done_*       count unit finished writing a bank
//            pru2ctrl_rd_done_vld_i    read unit finished the reading bank
//            ctrl2pru_start_*          one-cycle read start + bank id
//            ctrl_busy_o               any bank not IDLE
//            ctrl_timeout_o            read watchdog pulse
// Revision : 1.0 - initial multi-bank release
// ============================================================================
module sort_ctrl_mb
    import sort_ctrl_pkg::*;
#(
    parameter  int NUM_BANK    = 2,
    parameter  int TIMEOUT_CYC = 1024,
    localparam int BANK_W      = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctrl_vld_i,
    output logic              ctrl_rdy_o,
    output logic [BANK_W-1:0] ctrl_bank_o,
    input  logic              ctrl_input_done_vld_i,
    input  logic              cntu2ctrl_wr_done_vld_i,
    input  logic [BANK_W-1:0] cntu2ctrl_wr_done_bank_i,
    input  logic              pru2ctrl_rd_done_vld_i,
    output logic              ctrl2pru_start_vld_o,
    output logic [BANK_W-1:0] ctrl2pru_start_bank_o,
    output logic              ctrl_busy_o,
    output logic              ctrl_timeout_o
);

    logic [BANK_W-1:0]    r_wr_ptr;
    logic [BANK_W-1:0]    r_rd_ptr;
    logic                 r_wr_busy;

    logic [c_state_w-1:0] w_bank_state [NUM_BANK];
    logic [NUM_BANK-1:0]  w_bank_idle;
    logic [NUM_BANK-1:0]  w_bank_in_wr;
    logic [NUM_BANK-1:0]  w_bank_in_rd;
    logic [NUM_BANK-1:0]  w_bank_accept;
    logic [NUM_BANK-1:0]  w_bank_input_done;
    logic [NUM_BANK-1:0]  w_bank_wr_done;
    logic [NUM_BANK-1:0]  w_bank_rd_grant;
    logic [NUM_BANK-1:0]  w_bank_rd_done;
    logic [NUM_BANK-1:0]  w_bank_timeout;

    logic w_accept;
    logic w_start;
    logic w_any_rd;
    logic w_rd_release;
    logic w_timeout;

    // ------------------------------------------------------------------
    // Per-bank FSMs and strobe qualification
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_BANK; gi++) begin : g_bank
        localparam logic [BANK_W-1:0] c_id = BANK_W'(gi);

        assign w_bank_idle[gi]       = (w_bank_state[gi] == c_st_idle);
        assign w_bank_in_wr[gi]      = (w_bank_state[gi] == c_st_wr_data);
        assign w_bank_in_rd[gi]      = (w_bank_state[gi] == c_st_rd_data);

        assign w_bank_accept[gi]     = w_accept & (r_wr_ptr == c_id);
        // At most one bank is ever in WR_DATA / RD_DATA, so the untagged
        // input_done and rd_done strobes go to whichever bank holds it.
        assign w_bank_input_done[gi] = ctrl_input_done_vld_i & w_bank_in_wr[gi];
        assign w_bank_wr_done[gi]    = cntu2ctrl_wr_done_vld_i &
                                       (cntu2ctrl_wr_done_bank_i == c_id);
        assign w_bank_rd_grant[gi]   = w_start & (r_rd_ptr == c_id);
        assign w_bank_rd_done[gi]    = pru2ctrl_rd_done_vld_i & w_bank_in_rd[gi];
        assign w_bank_timeout[gi]    = w_timeout & w_bank_in_rd[gi];

        sort_ctrl_bank_fsm u_fsm (
            .clk          (clk),
            .rst          (rst),
            .i_accept     (w_bank_accept[gi]),
            .i_input_done (w_bank_input_done[gi]),
            .i_wr_done    (w_bank_wr_done[gi]),
            .i_rd_grant   (w_bank_rd_grant[gi]),
            .i_rd_done    (w_bank_rd_done[gi]),
            .i_timeout    (w_bank_timeout[gi]),
            .o_state      (w_bank_state[gi])
        );
    end

    // ------------------------------------------------------------------
    // Decode from registered state
    // ------------------------------------------------------------------
    assign w_any_rd   = |w_bank_in_rd;
    assign ctrl_rdy_o = ~r_wr_busy & (w_bank_state[r_wr_ptr] == c_st_idle);
    assign w_accept   = ctrl_vld_i & ctrl_rdy_o;

    // Only the oldest job (rd_ptr) may start, and only once the read unit
    // is free; this is what keeps starts in allocation order.
    assign w_start    = (w_bank_state[r_rd_ptr] == c_st_rd_pend) & ~w_any_rd;

    assign w_rd_release = (pru2ctrl_rd_done_vld_i & w_any_rd) | w_timeout;

    // ------------------------------------------------------------------
    // Pointers and write-busy flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_wr_busy <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= BANK_W'(ptr_inc(4'(r_wr_ptr), 5'(NUM_BANK)));
            end
            if (w_rd_release) begin
                r_rd_ptr <= BANK_W'(ptr_inc(4'(r_rd_ptr), 5'(NUM_BANK)));
            end
            // Accept needs wr_busy clear, so it can never coincide with an
            // input_done that is actually consumed.
            if (w_accept) begin
                r_wr_busy <= 1'b1;
            end else if (ctrl_input_done_vld_i) begin
                r_wr_busy <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional read watchdog
    // ------------------------------------------------------------------
`ifdef SORT_CTRL_RD_TIMEOUT_EN
    localparam int                  c_to_cnt_w = $clog2(TIMEOUT_CYC + 1);
    // The counter holds the number of RD_DATA cycles already completed, so
    // the cycle in which it equals TIMEOUT_CYC-1 is the TIMEOUT_CYC-th.
    localparam logic [c_to_cnt_w-1:0] c_to_last = c_to_cnt_w'(TIMEOUT_CYC - 1);

    logic [c_to_cnt_w-1:0] r_to_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (w_start) begin
            r_to_cnt <= '0;
        end else if (w_any_rd) begin
            r_to_cnt <= r_to_cnt + c_to_cnt_w'(1);
        end
    end

    // A rd_done arriving in the expiry cycle wins: normal completion.
    assign w_timeout = w_any_rd & (r_to_cnt == c_to_last) & ~pru2ctrl_rd_done_vld_i;
`else
    assign w_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ctrl_bank_o           = r_wr_ptr;
    assign ctrl2pru_start_vld_o  = w_start;
    assign ctrl2pru_start_bank_o = r_rd_ptr;
    assign ctrl_busy_o           = ~&w_bank_idle;
    assign ctrl_timeout_o        = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_sort_ctrl_mb.sv
`default_nettype none
// ============================================================================
// Module   : tb_sort_ctrl_mb
// Purpose  : Self-checking bench for sort_ctrl_mb. Instance A uses
//            NUM_BANK=2, instance B NUM_BANK=3, both TIMEOUT_CYC=16.
//            Read-start banks are checked against a scoreboard filled at
//            job acceptance; cycle timing is checked by directed steps.
// Revision : 1.0 - initial
// ============================================================================
module tb_sort_ctrl_mb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A (2 banks)
    logic       a_vld = 0, a_in_done = 0, a_wr_done = 0, a_rd_done = 0;
    logic [0:0] a_wr_bank = 0;
    logic       a_rdy, a_start, a_busy, a_timeout;
    logic [0:0] a_bank, a_start_bank;
    // Instance B (3 banks)
    logic       b_vld = 0, b_in_done = 0, b_wr_done = 0, b_rd_done = 0;
    logic [1:0] b_wr_bank = 0;
    logic       b_rdy, b_start, b_busy, b_timeout;
    logic [1:0] b_bank, b_start_bank;

    int n_chk  = 0;
    int n_fail = 0;
    logic [1:0] qa[$];
    logic [1:0] qb[$];

    sort_ctrl_mb #(.NUM_BANK(2), .TIMEOUT_CYC(16)) u_dut_a (
        .clk(clk), .rst(rst),
        .ctrl_vld_i(a_vld), .ctrl_rdy_o(a_rdy), .ctrl_bank_o(a_bank),
        .ctrl_input_done_vld_i(a_in_done),
        .cntu2ctrl_wr_done_vld_i(a_wr_done), .cntu2ctrl_wr_done_bank_i(a_wr_bank),
        .pru2ctrl_rd_done_vld_i(a_rd_done),
        .ctrl2pru_start_vld_o(a_start), .ctrl2pru_start_bank_o(a_start_bank),
        .ctrl_busy_o(a_busy), .ctrl_timeout_o(a_timeout)
    );

    sort_ctrl_mb #(.NUM_BANK(3), .TIMEOUT_CYC(16)) u_dut_b (
        .clk(clk), .rst(rst),
        .ctrl_vld_i(b_vld), .ctrl_rdy_o(b_rdy), .ctrl_bank_o(b_bank),
        .ctrl_input_done_vld_i(b_in_done),
        .cntu2ctrl_wr_done_vld_i(b_wr_done), .cntu2ctrl_wr_done_bank_i(b_wr_bank),
        .pru2ctrl_rd_done_vld_i(b_rd_done),
        .ctrl2pru_start_vld_o(b_start), .ctrl2pru_start_bank_o(b_start_bank),
        .ctrl_busy_o(b_busy), .ctrl_timeout_o(b_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle: pulses drop, outputs settle, then the
    // caller checks and drives the inputs for this cycle.
    task automatic nxt();
        @(negedge clk);
        a_vld = 0; a_in_done = 0; a_wr_done = 0; a_rd_done = 0;
        b_vld = 0; b_in_done = 0; b_wr_done = 0; b_rd_done = 0;
        #1;
    endtask

    task automatic nxt_n(input int n);
        for (int i = 0; i < n; i++) nxt();
    endtask

    task automatic acc_a(input logic [1:0] exp_bank);
        chk("a_acc_rdy", a_rdy, 1);
        chk("a_acc_bank", a_bank, exp_bank);
        a_vld = 1;
        qa.push_back(exp_bank);
    endtask

    task automatic acc_b(input logic [1:0] exp_bank);
        chk("b_acc_rdy", b_rdy, 1);
        chk("b_acc_bank", b_bank, exp_bank);
        b_vld = 1;
        qb.push_back(exp_bank);
    endtask

    task automatic wrd_a(input logic bank);
        a_wr_done = 1; a_wr_bank = bank;
    endtask

    task automatic wrd_b(input logic [1:0] bank);
        b_wr_done = 1; b_wr_bank = bank;
    endtask

    // Scoreboard: every read start must match the oldest accepted job.
    always @(negedge clk) begin
        if (!rst && a_start) begin
            n_chk++;
            assert (qa.size() > 0) else begin
                n_fail++;
                $error("FAIL a_sb_unexpected: observed start bank %0d expected no start", a_start_bank);
            end
            if (qa.size() > 0) begin
                logic [1:0] e;
                e = qa.pop_front();
                n_chk++;
                assert ({1'b0, a_start_bank} === e) else begin
                    n_fail++;
                    $error("FAIL a_sb_bank: observed %0d expected %0d", a_start_bank, e);
                end
            end
        end
        if (!rst && b_start) begin
            n_chk++;
            assert (qb.size() > 0) else begin
                n_fail++;
                $error("FAIL b_sb_unexpected: observed start bank %0d expected no start", b_start_bank);
            end
            if (qb.size() > 0) begin
                logic [1:0] e;
                e = qb.pop_front();
                n_chk++;
                assert (b_start_bank === e) else begin
                    n_fail++;
                    $error("FAIL b_sb_bank: observed %0d expected %0d", b_start_bank, e);
                end
            end
        end
    end

    initial begin
        // ---------------- reset ----------------
        rst = 1;
        nxt_n(3);
        rst = 0;
        nxt();
        chk("rst_a_rdy", a_rdy, 1);
        chk("rst_a_bank", a_bank, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_start", a_start, 0);
        chk("rst_a_timeout", a_timeout, 0);
        chk("rst_b_rdy", b_rdy, 1);
        chk("rst_b_busy", b_busy, 0);

        // ---------------- single job + ordering hazards (A) ----------------
        nxt(); acc_a(0);
        nxt(); chk("t1_busy", a_busy, 1); chk("t1_rdy_wrbusy", a_rdy, 0); chk("t1_bank", a_bank, 1);
        wrd_a(1); a_rd_done = 1;               // wr_done on IDLE bank, spurious rd_done
        nxt(); chk("t1_busy2", a_busy, 1); chk("t1_nostart0", a_start, 0);
        a_in_done = 1; wrd_a(0);               // wr_done in the same cycle as input_done
        nxt(); chk("t1_rdy_after_in_done", a_rdy, 1); chk("t1_nostart1", a_start, 0);
        nxt(); chk("t1_nostart2", a_start, 0);
        wrd_a(0);
        nxt(); chk("t1_start", a_start, 1); chk("t1_start_bank", a_start_bank, 0);
        nxt(); chk("t1_start_1cyc", a_start, 0); chk("t1_busy_rd", a_busy, 1);
        a_rd_done = 1;
        nxt(); chk("t1_idle", a_busy, 0);

        // ---------------- overlap (A): pointers wr=1 rd=1 ----------------
        nxt(); acc_a(1);
        nxt(); a_in_done = 1;
        nxt(); wrd_a(1);
        nxt(); chk("t2_startA", a_start, 1); chk("t2_startA_bank", a_start_bank, 1);
        nxt(); acc_a(0);
        nxt(); a_in_done = 1;
        nxt(); wrd_a(0);
        nxt(); chk("t2_blockedB0", a_start, 0);
        nxt(); chk("t2_blockedB1", a_start, 0); a_rd_done = 1;
        nxt(); chk("t2_startB", a_start, 1); chk("t2_startB_bank", a_start_bank, 0);
        nxt(); a_rd_done = 1;
        nxt(); chk("t2_idle", a_busy, 0);

        // ---------------- out-of-order cntu (A): wr=1 rd=1 ----------------
        nxt(); acc_a(1);
        nxt(); a_in_done = 1;
        nxt(); acc_a(0);
        nxt(); a_in_done = 1;
        nxt(); wrd_a(0);
        nxt(); chk("t3_wait_order0", a_start, 0);
        nxt(); chk("t3_wait_order1", a_start, 0); wrd_a(1);
        nxt(); chk("t3_start1", a_start, 1); chk("t3_start1_bank", a_start_bank, 1);
        nxt(); chk("t3_gap", a_start, 0); a_rd_done = 1;
        nxt(); chk("t3_start0", a_start, 1); chk("t3_start0_bank", a_start_bank, 0);
        nxt(); a_rd_done = 1; acc_a(1);        // rd_done and accept together
        nxt(); chk("t3_busy", a_busy, 1); chk("t3_bank_wrap", a_bank, 0); a_in_done = 1;
        nxt(); wrd_a(1);
        nxt(); chk("t3_start2", a_start, 1); chk("t3_start2_bank", a_start_bank, 1);
        nxt(); a_rd_done = 1;
        nxt(); chk("t3_idle", a_busy, 0);

        // ---------------- read watchdog (A): wr=0 rd=0 ----------------
        nxt(); acc_a(0);
        nxt(); a_in_done = 1;
        nxt(); acc_a(1);
        nxt(); a_in_done = 1;
        nxt(); wrd_a(0);
        nxt(); chk("t4_start", a_start, 1); chk("t4_start_bank", a_start_bank, 0); wrd_a(1);
        for (int k = 1; k <= 15; k++) begin
            nxt();
            chk("t4_no_timeout_early", a_timeout, 0);
            chk("t4_no_start_early", a_start, 0);
        end
        nxt();
`ifdef SORT_CTRL_RD_TIMEOUT_EN
        chk("t4_timeout", a_timeout, 1);
        nxt(); chk("t4_timeout_1cyc", a_timeout, 0);
        chk("t4_next_start", a_start, 1); chk("t4_next_bank", a_start_bank, 1);
        nxt(); a_rd_done = 1;
`else
        chk("t4_never_timeout", a_timeout, 0);
        for (int k = 0; k < 10; k++) begin
            nxt(); chk("t4_never_timeout_late", a_timeout, 0); chk("t4_held", a_start, 0);
        end
        a_rd_done = 1;
        nxt(); chk("t4_next_start", a_start, 1); chk("t4_next_bank", a_start_bank, 1);
        nxt(); a_rd_done = 1;
`endif
        nxt(); chk("t4_idle", a_busy, 0);

        // ---------------- full + wrap (B, 3 banks) ----------------
        nxt(); acc_b(0);
        nxt(); b_in_done = 1;
        nxt(); acc_b(1);
        nxt(); b_in_done = 1;
        nxt(); acc_b(2);
        nxt(); b_in_done = 1;
        nxt(); chk("t5_full_rdy", b_rdy, 0); chk("t5_full_bank", b_bank, 0); b_vld = 1;
        nxt(); chk("t5_ignored_rdy", b_rdy, 0); chk("t5_ignored_bank", b_bank, 0); wrd_b(0);
        nxt(); chk("t5_start0", b_start, 1); chk("t5_start0_bank", b_start_bank, 0); wrd_b(2);
        nxt(); wrd_b(1);
        nxt(); b_rd_done = 1;
        nxt(); chk("t5_rdy_after_free", b_rdy, 1); chk("t5_start1", b_start, 1);
        acc_b(0);
        nxt(); chk("t5_bank_next", b_bank, 1); chk("t5_rdy_wrbusy", b_rdy, 0); b_in_done = 1;
        nxt(); b_rd_done = 1;
        nxt(); chk("t5_start2", b_start, 1); chk("t5_start2_bank", b_start_bank, 2);
        nxt(); b_rd_done = 1;
        nxt(); wrd_b(0);
        nxt(); chk("t5_start3", b_start, 1); chk("t5_start3_bank", b_start_bank, 0);
        nxt(); b_rd_done = 1;
        nxt(); chk("t5_idle", b_busy, 0);

        // ---------------- reset mid-operation (B) ----------------
        nxt(); chk("t6_rdy", b_rdy, 1); chk("t6_bank", b_bank, 1); b_vld = 1;
        nxt(); chk("t6_busy", b_busy, 1); rst = 1;
        nxt(); rst = 0;
        nxt(); chk("t6_busy_cleared", b_busy, 0); chk("t6_bank_cleared", b_bank, 0);
        chk("t6_rdy_after", b_rdy, 1);
        nxt_n(4);
        chk("t6_no_start", b_start, 0);

        chk("end_qa_empty", qa.size(), 0);
        chk("end_qb_empty", qb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
